id_ex_skid_reg: RTL and testbench

- Parametrised successor of the ID/EX pipeline register: registers decode-stage payload into execute with a valid/ready handshake.
- A 2-entry skid buffer sustains full throughput while keeping in_ready registered, so the ready path is not combinational.
- Synchronous flush inserts a bubble; control fields are forced to zero whenever no valid entry is presented.
- Sits between the decoder/register-file read and the ALU/forwarding logic.

---
 rtl/id_ex_skid_reg.sv | 180 ++++++++++++++++++
 tb/tb_id_ex_skid_reg.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_skid_reg
// Purpose  : ID/EX pipeline register with a valid/ready handshake and a
//            2-entry skid buffer. Decode payload is registered into execute
//            with one cycle of latency and full throughput. in_ready comes
//            straight from a flop, so upstream never sees a combinational
//            path from out_ready.
//            A synchronous flush drops every held entry. Control fields read
//            as zero whenever no valid entry is presented, so execute may
//            treat ctrl == 0 as a NOP.
// Ports    : clk        rising-edge clock
//            rst        synchronous, active-high reset
//            flush      kill all held entries (mispredict / trap)
//            in_valid   decode payload valid
//            in_ready   buffer can accept (registered)
//            in_ctrl    decode control fields      [CTRL_W]
//            in_data    decode payload             [DATA_W]
//            out_valid  execute payload valid
//            out_ready  execute can consume
//            out_ctrl   control, zero when out_valid == 0
//            out_data   payload (held across flush)
//            stall_cnt  cycles with out_valid & ~out_ready   (ID_EX_PERF_EN)
//            kill_cnt   flushes that discarded a valid entry (ID_EX_PERF_EN)
// Options  : define ID_EX_PERF_EN to add the saturating 32-bit counters.
// Revision : 1.0  initial release
// ============================================================================
module id_ex_skid_reg #(
  parameter int DATA_W = 143,
  parameter int CTRL_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       kill_cnt
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,  // main invalid, skid invalid
    S_ONE   = 2'd1,  // main valid,   skid invalid
    S_FULL  = 2'd2   // main valid,   skid valid
  } state_e;

  state_e              state_q,     state_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic                in_ready_q,  in_ready_d;

  logic                in_fire;
  logic                out_fire;
  logic                main_valid;

  assign main_valid = (state_q != S_EMPTY);
  // in_ready_q always equals "skid empty"; it is kept as its own flop so the
  // upstream ready path starts at a register output.
  assign in_fire    = in_valid & in_ready_q;
  assign out_fire   = main_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    in_ready_d  = in_ready_q;

    if (flush) begin
      // Payload is left alone; only the control fields are bubbled.
      state_d     = S_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      in_ready_d  = 1'b1;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            state_d     = S_ONE;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (in_fire) begin
            // Execute stalled: park the new beat behind the current one.
            state_d     = S_FULL;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            in_ready_d  = 1'b0;
          end else if (out_fire) begin
            state_d     = S_EMPTY;
            main_ctrl_d = '0;
          end
        end
        S_FULL: begin
          // in_ready_q is low here, so no new beat can arrive this cycle.
          if (out_fire) begin
            state_d     = S_ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = '0;
            in_ready_d  = 1'b1;
          end
        end
        default: begin
          state_d     = S_EMPTY;
          main_ctrl_d = '0;
          skid_ctrl_d = '0;
          in_ready_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid;
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;

`ifdef ID_EX_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] kill_cnt_q;

  // Both counters saturate; only reset clears them (flush does not).
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      if (main_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      // A non-empty buffer always has a valid main entry, so main_valid
      // alone tells whether the flush discarded anything.
      if (flush && main_valid && (kill_cnt_q != 32'hFFFF_FFFF)) begin
        kill_cnt_q <= kill_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign kill_cnt  = kill_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_skid_reg
// Purpose  : Self-checking bench for id_ex_skid_reg. A directed vector table
//            walks reset, streaming, backpressure, flush and reset-mid-
//            transfer; a random phase follows. Every cycle is also compared
//            against a queue-based model of a 2-deep FIFO.
// Revision : 1.0  initial release
// ============================================================================
module tb_id_ex_skid_reg;

  localparam int DATA_W = 143;
  localparam int CTRL_W = 11;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
`ifdef ID_EX_PERF_EN
  logic [31:0]       stall_cnt;
  logic [31:0]       kill_cnt;
`endif

  id_ex_skid_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data)
`ifdef ID_EX_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .kill_cnt  (kill_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: a 2-deep FIFO ----------------
  typedef struct {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } beat_t;

  beat_t             m_q[$];
  logic [DATA_W-1:0] m_last = '0;   // payload currently sitting in the output register
  longint            m_stall = 0;
  longint            m_kill  = 0;

  task automatic model_edge(input logic r, input logic f, input logic iv, input logic ordy,
                            input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    bit    acc;
    bit    cons;
    beat_t b;
    acc  = iv && (m_q.size() < 2);
    cons = (m_q.size() > 0) && ordy;
    if (r) begin
      m_q.delete();
      m_last  = '0;
      m_stall = 0;
      m_kill  = 0;
    end else begin
      if (m_q.size() > 0 && !ordy && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (f) begin
        if (m_q.size() > 0 && m_kill < 64'hFFFF_FFFF) m_kill++;
        m_q.delete();
      end else begin
        if (cons) void'(m_q.pop_front());
        if (acc) begin
          b.c = c;
          b.d = d;
          m_q.push_back(b);
        end
      end
      if (m_q.size() > 0) m_last = m_q[0].d;
    end
  endtask

  task automatic model_compare();
    logic              ev;
    logic [CTRL_W-1:0] ec;
    ev = (m_q.size() > 0);
    ec = ev ? m_q[0].c : '0;
    chk("model.out_valid", 160'(out_valid), 160'(ev));
    chk("model.in_ready",  160'(in_ready),  160'(m_q.size() < 2));
    chk("model.out_ctrl",  160'(out_ctrl),  160'(ec));
    chk("model.out_data",  160'(out_data),  160'(m_last));
`ifdef ID_EX_PERF_EN
    chk("model.stall_cnt", 160'(stall_cnt), 160'(m_stall));
    chk("model.kill_cnt",  160'(kill_cnt),  160'(m_kill));
`endif
  endtask

  // Drive one cycle of inputs at the negedge, advance the model at the
  // posedge, compare just after it.
  task automatic step(input logic r, input logic f, input logic iv, input logic ordy,
                      input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    @(negedge clk);
    rst       = r;
    flush     = f;
    in_valid  = iv;
    out_ready = ordy;
    in_ctrl   = c;
    in_data   = d;
    @(posedge clk);
    model_edge(r, f, iv, ordy, c, d);
    #1;
    model_compare();
  endtask

  // ---------------- directed vector table ----------------
  function automatic logic [DATA_W-1:0] mkdata(input logic [7:0] t);
    return {{17{t}}, 7'h5b};
  endfunction

  function automatic logic [CTRL_W-1:0] mkctrl(input logic [7:0] t);
    return {3'b101, t};
  endfunction

  typedef struct {
    logic       r, f, iv, ordy;
    logic [7:0] tag;
    logic       ev, er;
    logic       ezero;   // expected out_data is all-zero (reset value)
    logic [7:0] etag;
  } vec_t;

  function automatic vec_t v(input logic r, input logic f, input logic iv, input logic ordy,
                             input logic [7:0] tag, input logic ev, input logic er,
                             input logic ezero, input logic [7:0] etag);
    vec_t x;
    x.r = r; x.f = f; x.iv = iv; x.ordy = ordy; x.tag = tag;
    x.ev = ev; x.er = er; x.ezero = ezero; x.etag = etag;
    return x;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [DATA_W-1:0] ed;
    logic [159:0]      rnd;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;

    //          r  f  iv or  tag    ev er z  etag
    tbl.push_back(v(1, 0, 0, 0, 8'h00, 0, 1, 1, 8'h00));   // reset, 2 cycles
    tbl.push_back(v(1, 0, 0, 0, 8'h00, 0, 1, 1, 8'h00));
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 0, 1, 1, 8'h00));   // idle
    for (int i = 0; i < 8; i++)                              // streaming 0x10..0x17
      tbl.push_back(v(0, 0, 1, 1, 8'(8'h10 + i), 1, 1, 0, 8'(8'h10 + i)));
    tbl.push_back(v(0, 0, 0, 1, 8'h00, 0, 1, 0, 8'h17));   // drains, data held
    tbl.push_back(v(0, 0, 1, 0, 8'hA1, 1, 1, 0, 8'hA1));   // backpressure
    tbl.push_back(v(0, 0, 1, 0, 8'hA2, 1, 0, 0, 8'hA1));   // FULL, ready drops
    tbl.push_back(v(0, 0, 1, 0, 8'hA3, 1, 0, 0, 8'hA1));   // A3 refused
    tbl.push_back(v(0, 0, 1, 1, 8'hA3, 1, 1, 0, 8'hA2));   // release: A1 out, A3 still refused
    tbl.push_back(v(0, 0, 1, 1, 8'hA3, 1, 1, 0, 8'hA3));   // A3 accepted
    tbl.push_back(v(0, 0, 0, 1, 8'h00, 0, 1, 0, 8'hA3));
    tbl.push_back(v(0, 0, 1, 0, 8'hB1, 1, 1, 0, 8'hB1));   // fill for flush
    tbl.push_back(v(0, 0, 1, 0, 8'hB2, 1, 0, 0, 8'hB1));
    tbl.push_back(v(0, 1, 1, 0, 8'hB3, 0, 1, 0, 8'hB1));   // flush while FULL
    tbl.push_back(v(0, 0, 0, 1, 8'h00, 0, 1, 0, 8'hB1));   // B3 never appears
    tbl.push_back(v(0, 0, 1, 0, 8'hC1, 1, 1, 0, 8'hC1));
    tbl.push_back(v(0, 1, 1, 0, 8'hC2, 0, 1, 0, 8'hC1));   // flush drops accepted beat
    tbl.push_back(v(0, 1, 0, 0, 8'h00, 0, 1, 0, 8'hC1));   // flush while EMPTY
    tbl.push_back(v(0, 0, 1, 0, 8'hD1, 1, 1, 0, 8'hD1));
    tbl.push_back(v(1, 0, 1, 0, 8'hD2, 0, 1, 1, 8'h00));   // reset in ONE, D2 ignored
    tbl.push_back(v(0, 0, 0, 1, 8'h00, 0, 1, 1, 8'h00));

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].ordy, mkctrl(tbl[i].tag), mkdata(tbl[i].tag));
      ed = tbl[i].ezero ? '0 : mkdata(tbl[i].etag);
      chk($sformatf("vec%0d.out_valid", i), 160'(out_valid), 160'(tbl[i].ev));
      chk($sformatf("vec%0d.in_ready", i),  160'(in_ready),  160'(tbl[i].er));
      chk($sformatf("vec%0d.out_ctrl", i),  160'(out_ctrl),
          160'(tbl[i].ev ? mkctrl(tbl[i].etag) : '0));
      chk($sformatf("vec%0d.out_data", i),  160'(out_data),  160'(ed));
    end

`ifdef ID_EX_PERF_EN
    // Stall for exactly 5 cycles after a fresh reset.
    step(1, 0, 0, 0, '0, '0);
    step(0, 0, 1, 0, mkctrl(8'hE1), mkdata(8'hE1));   // load; no stall counted yet
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, '0, '0);
    chk("perf.stall5", 160'(stall_cnt), 160'(32'd5));
    step(0, 1, 0, 1, '0, '0);
    chk("perf.kill1", 160'(kill_cnt), 160'(32'd1));
`endif

    // Random phase; out_ready bias varies so FULL is reached often.
    for (int i = 0; i < 3000; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 3) != 0),
           (i % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
           CTRL_W'($urandom), rnd[DATA_W-1:0]);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
